// File: rtl/jtkunio_romarb_pkg.sv
// Shared definitions for the two-requester ROM arbiter: FSM states and
// requester indices.
package jtkunio_romarb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_SCR = 2'd1,
        BUSY_OBJ = 2'd2
    } arb_state_e;

    localparam logic REQ_SCR = 1'b0;
    localparam logic REQ_OBJ = 1'b1;

endpackage

// File: rtl/jtkunio_romarb_slot.sv
// One-entry cache for a single requester: the tag/data/valid registers, the
// hit compare, the registered ok flag and the pending-miss indication.
module jtkunio_romarb_slot #(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_i,
    input  logic          cs_i,
    input  logic          fill_i,
    input  logic [AW-1:0] fill_addr_i,
    input  logic [DW-1:0] fill_data_i,
    output logic [DW-1:0] data_o,
    output logic          ok_o,
    output logic          miss_o
);

    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          valid_q;
    logic          ok_q;
    logic          hit;
    logic          ok_d;

    assign hit    = valid_q && (addr_q == addr_i);
    assign miss_o = cs_i && !hit;

    // The fill bypass lets ok rise in the cycle right after the sdr_ok pulse,
    // while a requester that moved away or dropped cs never sees a false ok.
    assign ok_d = cs_i && (hit || (fill_i && (fill_addr_i == addr_i)));

    // NOTE: the data register is cleared on reset on purpose, so the data
    // output reads zero after reset instead of whatever was last fetched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ok_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values regardless of statement order.
            ok_q <= ok_d;
            if (fill_i) begin
                addr_q  <= fill_addr_i;
                data_q  <= fill_data_i;
                valid_q <= 1'b1;
            end
        end
    end

    assign data_o = data_q;
    assign ok_o   = ok_q;

endmodule

// File: rtl/jtkunio_romarb.sv
// Round-robin arbiter sharing one downstream ROM port between the scroll and
// object requesters, each fronted by a one-entry cache.
module jtkunio_romarb
    import jtkunio_romarb_pkg::*;
#(
    parameter int AW = 17,
    parameter int DW = 32
) (
    input  logic          rst,
    input  logic          clk,
    input  logic [AW-1:0] scr_addr,
    input  logic          scr_cs,
    output logic [DW-1:0] scr_data,
    output logic          scr_ok,
    input  logic [AW-1:0] obj_addr,
    input  logic          obj_cs,
    output logic [DW-1:0] obj_data,
    output logic          obj_ok,
    output logic [AW-1:0] sdr_addr,
    output logic          sdr_cs,
    input  logic [DW-1:0] sdr_data,
    input  logic          sdr_ok
);

    arb_state_e    state_q;
    logic [AW-1:0] sdr_addr_q;
    logic          sdr_cs_q;
    logic          last_q;
    logic          scr_miss;
    logic          obj_miss;
    logic          scr_fill;
    logic          obj_fill;

    // sdr_ok only counts while a transfer is in flight.
    assign scr_fill = (state_q == BUSY_SCR) && sdr_ok;
    assign obj_fill = (state_q == BUSY_OBJ) && sdr_ok;

    jtkunio_romarb_slot #(.AW(AW), .DW(DW)) u_scr_slot (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (scr_addr),
        .cs_i        (scr_cs),
        .fill_i      (scr_fill),
        .fill_addr_i (sdr_addr_q),
        .fill_data_i (sdr_data),
        .data_o      (scr_data),
        .ok_o        (scr_ok),
        .miss_o      (scr_miss)
    );

    jtkunio_romarb_slot #(.AW(AW), .DW(DW)) u_obj_slot (
        .clk         (clk),
        .rst         (rst),
        .addr_i      (obj_addr),
        .cs_i        (obj_cs),
        .fill_i      (obj_fill),
        .fill_addr_i (sdr_addr_q),
        .fill_data_i (sdr_data),
        .data_o      (obj_data),
        .ok_o        (obj_ok),
        .miss_o      (obj_miss)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sdr_cs_q   <= 1'b0;
            sdr_addr_q <= '0;
            last_q     <= REQ_OBJ;
        end else begin
            case (state_q)
                IDLE: begin
                    // Scroll wins unless obj also misses and scroll went last.
                    if (scr_miss && (!obj_miss || last_q == REQ_OBJ)) begin
                        sdr_addr_q <= scr_addr;
                        sdr_cs_q   <= 1'b1;
                        last_q     <= REQ_SCR;
                        state_q    <= BUSY_SCR;
                    end else if (obj_miss) begin
                        sdr_addr_q <= obj_addr;
                        sdr_cs_q   <= 1'b1;
                        last_q     <= REQ_OBJ;
                        state_q    <= BUSY_OBJ;
                    end
                end
                BUSY_SCR, BUSY_OBJ: begin
                    if (sdr_ok) begin
                        sdr_cs_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    sdr_cs_q <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign sdr_addr = sdr_addr_q;
    assign sdr_cs   = sdr_cs_q;

endmodule

// File: tb/tb_jtkunio_romarb.sv
// Directed scenarios followed by random traffic, every cycle compared against
// a transaction-level model of the two caches and the shared ROM port.
module tb_jtkunio_romarb;

    localparam int AW = 17;
    localparam int DW = 32;

    logic          rst;
    logic          clk;
    logic [AW-1:0] scr_addr;
    logic          scr_cs;
    logic [DW-1:0] scr_data;
    logic          scr_ok;
    logic [AW-1:0] obj_addr;
    logic          obj_cs;
    logic [DW-1:0] obj_data;
    logic          obj_ok;
    logic [AW-1:0] sdr_addr;
    logic          sdr_cs;
    logic [DW-1:0] sdr_data;
    logic          sdr_ok;

    int n_vec = 0;
    int n_err = 0;

    jtkunio_romarb #(.AW(AW), .DW(DW)) dut (
        .rst      (rst),
        .clk      (clk),
        .scr_addr (scr_addr),
        .scr_cs   (scr_cs),
        .scr_data (scr_data),
        .scr_ok   (scr_ok),
        .obj_addr (obj_addr),
        .obj_cs   (obj_cs),
        .obj_data (obj_data),
        .obj_ok   (obj_ok),
        .sdr_addr (sdr_addr),
        .sdr_cs   (sdr_cs),
        .sdr_data (sdr_data),
        .sdr_ok   (sdr_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: each requester owns a cached word; the ROM port carries at
    // most one outstanding fetch, tagged with its owner and address.
    logic [AW-1:0] c_addr [2];
    logic [DW-1:0] c_data [2];
    bit            c_valid[2];
    bit            m_ok   [2];
    bit            fetching;
    int            owner;
    logic [AW-1:0] fetch_addr;
    int            last_served;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            c_addr[i]  = '0;
            c_data[i]  = '0;
            c_valid[i] = 0;
            m_ok[i]    = 0;
        end
        fetching    = 0;
        owner       = 0;
        fetch_addr  = '0;
        last_served = 1;
    endtask

    task automatic model_edge();
        logic [AW-1:0] a[2];
        bit            c[2];
        bit            want[2];
        a[0] = scr_addr; a[1] = obj_addr;
        c[0] = scr_cs;   c[1] = obj_cs;
        for (int i = 0; i < 2; i++) begin
            bit cached, arriving;
            cached   = c_valid[i] && c_addr[i] == a[i];
            arriving = fetching && owner == i && sdr_ok && fetch_addr == a[i];
            m_ok[i]  = c[i] && (cached || arriving);
            want[i]  = c[i] && !cached;
        end
        if (fetching) begin
            if (sdr_ok) begin
                c_addr[owner]  = fetch_addr;
                c_data[owner]  = sdr_data;
                c_valid[owner] = 1;
                fetching       = 0;
            end
        end else if (want[0] || want[1]) begin
            if (want[0] && want[1]) owner = 1 - last_served;
            else                    owner = want[0] ? 0 : 1;
            fetching    = 1;
            fetch_addr  = a[owner];
            last_served = owner;
        end
    endtask

    task automatic compare_all();
        check("sdr_cs",   64'(sdr_cs),   64'(fetching));
        check("sdr_addr", 64'(sdr_addr), 64'(fetch_addr));
        check("scr_ok",   64'(scr_ok),   64'(m_ok[0]));
        check("obj_ok",   64'(obj_ok),   64'(m_ok[1]));
        check("scr_data", 64'(scr_data), 64'(c_data[0]));
        check("obj_data", 64'(obj_data), 64'(c_data[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input bit sc, input logic [AW-1:0] sa, input bit oc, input logic [AW-1:0] oa);
        scr_cs = sc; scr_addr = sa; obj_cs = oc; obj_addr = oa;
    endtask

    task automatic respond(input bit ok, input logic [DW-1:0] d);
        sdr_ok = ok; sdr_data = d;
    endtask

    logic [AW-1:0] pool[4];

    initial begin
        rst = 1'b1;
        drive(0, '0, 0, '0);
        respond(0, '0);
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        check("reset_sdr_cs", 64'(sdr_cs), 64'd0);
        rst = 1'b0;

        // Cold miss, then a hit on the same address.
        drive(1, 17'h00A42, 0, '0);
        tick();
        check("cold_sdr_cs", 64'(sdr_cs), 64'd1);
        check("cold_sdr_addr", 64'(sdr_addr), 64'h00A42);
        tick(); tick();
        respond(1, 32'hDEADBEEF);
        tick();
        respond(0, '0);
        check("cold_scr_ok", 64'(scr_ok), 64'd1);
        check("cold_scr_data", 64'(scr_data), 64'hDEADBEEF);
        drive(0, 17'h00A42, 0, '0);
        tick();
        drive(1, 17'h00A42, 0, '0);
        tick();
        check("hit_scr_ok", 64'(scr_ok), 64'd1);
        check("hit_no_sdr_cs", 64'(sdr_cs), 64'd0);

        // Tie after reset: scroll first; scroll re-misses at fill so obj wins.
        rst = 1'b1; model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1, 17'h00010, 1, 17'h00020);
        tick();
        check("tie1_addr", 64'(sdr_addr), 64'h00010);
        respond(1, 32'h11111111);
        tick();
        respond(0, '0);
        check("tie1_scr_ok", 64'(scr_ok), 64'd1);
        drive(1, 17'h00011, 1, 17'h00020);
        tick();
        check("tie2_addr", 64'(sdr_addr), 64'h00020);
        respond(1, 32'h22222222);
        tick();
        respond(0, '0);
        check("tie2_obj_ok", 64'(obj_ok), 64'd1);
        tick();
        check("tie3_addr", 64'(sdr_addr), 64'h00011);
        respond(1, 32'h33333333);
        tick();
        respond(0, '0);

        // Address change in flight.
        drive(1, 17'h00100, 1, 17'h00020);
        tick();
        check("chg_addr0", 64'(sdr_addr), 64'h00100);
        drive(1, 17'h00101, 1, 17'h00020);
        tick();
        check("chg_hold", 64'(sdr_addr), 64'h00100);
        respond(1, 32'h44444444);
        tick();
        respond(0, '0);
        check("chg_scr_ok", 64'(scr_ok), 64'd0);
        check("chg_sdr_cs", 64'(sdr_cs), 64'd0);
        tick();
        check("chg_reissue", 64'(sdr_addr), 64'h00101);
        respond(1, 32'h55555555);
        tick();
        respond(0, '0);

        // Obj fill at 0x2000, then an obj hit while scroll is fetching.
        drive(0, 17'h00101, 1, 17'h02000);
        tick();
        respond(1, 32'h66666666);
        tick();
        respond(0, '0);
        drive(1, 17'h00300, 1, 17'h02000);
        tick();
        check("busy_sdr_cs", 64'(sdr_cs), 64'd1);
        tick();
        check("busy_obj_ok", 64'(obj_ok), 64'd1);
        respond(1, 32'h77777777);
        tick();
        respond(0, '0);

        // Reset in the middle of an obj fetch; a stray ack writes nothing.
        drive(0, 17'h00300, 1, 17'h03000);
        tick();
        check("rst_busy", 64'(sdr_cs), 64'd1);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst_sdr_cs", 64'(sdr_cs), 64'd0);
        check("rst_obj_ok", 64'(obj_ok), 64'd0);
        check("rst_obj_data", 64'(obj_data), 64'd0);
        @(negedge clk);
        drive(0, 17'h00300, 0, 17'h03000);
        rst = 1'b0;
        respond(1, 32'hBADBAD00);
        tick();
        respond(0, '0);
        check("stray_obj_data", 64'(obj_data), 64'd0);
        drive(0, 17'h00300, 1, 17'h02000);
        tick();
        check("rst_cleared_valid", 64'(sdr_cs), 64'd1);
        respond(1, 32'h88888888);
        tick();
        respond(0, '0);

        // Random traffic with a small address pool so hits and ties occur.
        pool[0] = 17'h00001; pool[1] = 17'h00002; pool[2] = 17'h1FFFF; pool[3] = 17'h00A42;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) scr_addr = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) obj_addr = pool[$urandom_range(0, 3)];
            scr_cs = ($urandom_range(0, 3) != 0);
            obj_cs = ($urandom_range(0, 3) != 0);
            sdr_data = $urandom;
            sdr_ok = sdr_cs ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtkunio_romarb.md
JTKUNIO_ROMARB -- requirements
Module: jtkunio_romarb

Interface
REQ-001 SHALL have parameter AW, default 17: requester and downstream ROM address width (word address).
REQ-002 SHALL have parameter DW, default 32: ROM data width.
REQ-003 SHALL have ports: rst input 1, asynchronous active-high reset; clk input 1, the single clock.
REQ-004 SHALL have port scr_addr input AW: scroll tile ROM address.
REQ-005 SHALL have port scr_cs input 1: scroll request.
REQ-006 SHALL have port scr_data output DW: scroll data.
REQ-007 SHALL have port scr_ok output 1: scr_data valid for the current scr_addr.
REQ-008 SHALL have ports obj_addr input AW, obj_cs input 1, obj_data output DW and obj_ok output 1: object requester, with the same meanings as the scroll ports.
REQ-009 SHALL have port sdr_addr output AW: downstream ROM address.
REQ-010 SHALL have port sdr_cs output 1: downstream request.
REQ-011 SHALL have port sdr_data input DW: downstream data.
REQ-012 SHALL have port sdr_ok input 1: one-cycle pulse; sdr_data is valid in that cycle.

Function
REQ-013 SHALL keep one cache entry per requester: address, data and a valid flag.
REQ-014 SHALL register xx_ok each clock as: xx_cs, AND cache valid, AND cache address == xx_addr. A hit therefore gives xx_ok one cycle after the cs/addr sample.
REQ-015 SHALL drive xx_data continuously from that requester's cache data register.
REQ-016 SHALL treat xx_cs high with a missing or mismatched cache entry as a pending miss.
REQ-017 SHALL use FSM states IDLE, BUSY_SCR and BUSY_OBJ.
REQ-018 IDLE: SHALL stay in IDLE when neither requester has a pending miss.
REQ-019 IDLE, one miss pending: SHALL grant that requester.
REQ-020 IDLE, both misses pending: SHALL grant the requester not granted last (round-robin).
REQ-021 On grant, the block SHALL latch the requester address into sdr_addr, set sdr_cs=1 and enter BUSY_x in the next cycle.
REQ-022 BUSY_x SHALL hold sdr_cs and sdr_addr stable until sdr_ok.
REQ-023 On sdr_ok the block SHALL:
- write sdr_data and the latched address into cache x and set valid;
- drop sdr_cs;
- return to IDLE.
REQ-024 Miss latency: xx_ok SHALL rise exactly one cycle after the sdr_ok cycle, provided xx_addr is unchanged.
REQ-025 A requester address change during BUSY SHALL NOT abort the transfer: the fill completes under the latched address, xx_ok stays low, and the new address is arbitrated from IDLE.
REQ-026 Dropping xx_cs during BUSY SHALL still complete the fill, and xx_ok SHALL stay low.
REQ-027 A grant SHALL NOT be issued in the same cycle as sdr_ok; there is at most one outstanding downstream request.
REQ-028 Hits for the non-granted requester SHALL continue to be served during BUSY.
REQ-029 sdr_ok received while in IDLE SHALL be ignored.

Reset
REQ-030 While rst is high, and on its asynchronous assertion, the block SHALL set:
- state=IDLE;
- sdr_cs=0, sdr_addr=0;
- scr_ok=0, obj_ok=0;
- both valid flags=0;
- cache data=0, so xx_data=0;
- last-grant=obj, so scroll wins the first tie.
REQ-031 A reset asserted mid-transfer SHALL abandon the transfer without a cache write. After release, a stale sdr_ok pulse SHALL be ignored (REQ-029).

Structure
REQ-032 FSM state encodings and the requester index constants (SCR=0, OBJ=1) SHALL live in the shared jtkunio package/include file.
REQ-033 The per-requester cache (address/data/valid registers, hit compare, ok register) SHALL be one sub-module, jtkunio_romarb_slot, instantiated twice.
REQ-034 The RTL SHALL be 120-400 lines.

Verification
REQ-035 Cold miss: after reset, scr_cs=1, scr_addr=0x00A42 → sdr_cs=1 with sdr_addr=0x00A42; sdr_ok with data 0xDEADBEEF → scr_ok=1 and scr_data=0xDEADBEEF one cycle later.
REQ-036 Hit: repeat the same scr_addr after the fill → scr_ok=1 one cycle after cs, with no new sdr_cs.
REQ-037 Tie: scr and obj miss in the same cycle after reset → scroll is served first and obj next; a second simultaneous miss pair → obj is served first.
REQ-038 Address change in flight: scr_addr goes 0x100→0x101 during BUSY_SCR → fill 0x100 completes with scr_ok=0, then a new request for 0x101 is issued.
REQ-039 Reset mid-transfer: rst pulsed in BUSY_OBJ → sdr_cs=0, obj_ok=0 and valid flags cleared immediately; a stray sdr_ok after release writes nothing.
REQ-040 Hit during BUSY: obj cache holds 0x2000, scroll fill in progress, obj_addr=0x2000 → obj_ok=1 next cycle.
